// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide Avalon-MM memory port among PORTS cache requesters.
// Optional: define CACHE_MEM_ARB_WRITE_PRIO_EN to favour pending writes over reads at arbitration.
module cache_mem_arbiter #(
    parameter int PORTS  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PORTS*ADDR_W-1:0]   req_address,
    input  logic [PORTS-1:0]          req_read,
    input  logic [PORTS-1:0]          req_write,
    input  logic [PORTS*LINE_W-1:0]   req_writedata,
    output logic [PORTS-1:0]          req_waitrequest,
    output logic [LINE_W-1:0]         req_readdata,
    output logic [ADDR_W-1:0]         mem_address,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [LINE_W-1:0]         mem_writedata,
    input  logic                      mem_waitrequest,
    input  logic [LINE_W-1:0]         mem_readdata
);
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]       gnt_q, gnt_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [LINE_W-1:0]   mem_writedata_q, mem_writedata_d;
    logic [PORTS-1:0]    req_waitrequest_q, req_waitrequest_d;
    logic [LINE_W-1:0]   req_readdata_q, req_readdata_d;

    logic [PORTS-1:0]    cand;
    logic                found;
    int                  win;

    always_comb begin
        int idx;
        idx   = 0;
        cand  = req_read | req_write;
`ifdef CACHE_MEM_ARB_WRITE_PRIO_EN
        // Writebacks drain ahead of refills so an evicted line reaches memory first.
        if (|req_write) cand = req_write;
`endif
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < PORTS; k++) begin
            idx = (int'(rr_ptr_q) + k) % PORTS;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        gnt_d             = gnt_q;
        mem_address_d     = mem_address_q;
        mem_read_d        = mem_read_q;
        mem_write_d       = mem_write_q;
        mem_writedata_d   = mem_writedata_q;
        req_waitrequest_d = req_waitrequest_q;
        req_readdata_d    = req_readdata_q;
        case (state_q)
            IDLE: if (found) begin
                gnt_d           = PW'(win);
                mem_address_d   = req_address[win*ADDR_W +: ADDR_W];
                mem_writedata_d = req_writedata[win*LINE_W +: LINE_W];
                mem_write_d     = req_write[win];
                mem_read_d      = ~req_write[win];
                rr_ptr_d        = PW'((win + 1) % PORTS);
                state_d         = BUSY;
            end
            BUSY: if (!mem_waitrequest) begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (mem_read_q) req_readdata_d = mem_readdata;
                req_waitrequest_d[gnt_q] = 1'b0;
                state_d     = DONE;
            end
            DONE: begin
                req_waitrequest_d = '1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            rr_ptr_q          <= '0;
            gnt_q             <= '0;
            mem_address_q     <= '0;
            mem_read_q        <= 1'b0;
            mem_write_q       <= 1'b0;
            mem_writedata_q   <= '0;
            req_waitrequest_q <= '1;
            req_readdata_q    <= '0;
        end else begin
            state_q           <= state_d;
            rr_ptr_q          <= rr_ptr_d;
            gnt_q             <= gnt_d;
            mem_address_q     <= mem_address_d;
            mem_read_q        <= mem_read_d;
            mem_write_q       <= mem_write_d;
            mem_writedata_q   <= mem_writedata_d;
            req_waitrequest_q <= req_waitrequest_d;
            req_readdata_q    <= req_readdata_d;
        end
    end

    assign req_waitrequest = req_waitrequest_q;
    assign req_readdata    = req_readdata_q;
    assign mem_address     = mem_address_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_writedata   = mem_writedata_q;

endmodule
